grey_mac_sched: RTL and testbench
=================================

// Module: grey_mac_sched
// PURPOSE
//  Time-multiplexed luma engine: computes grey = (cR*R + cG*G + cB*B) >> 8 with ONE shared
//  8x8 multiplier, sequenced over three cycles by an FSM. Sits between the RGB pixel source
//  and the edge-detection front end. Valid/ready handshake on both sides.
//  Coefficients are runtime-programmable, defaulting to the NTSC set 77/150/29.
// PARAMETERS
//  PIX_W   8    pixel channel and grey output width
//  COEF_W  8    coefficient width (unsigned)
//  ACC_W   18   accumulator width; must hold 3*(2^PIX_W-1)*(2^COEF_W-1)
//  DEF_CR  77   reset value of the R coefficient
//  DEF_CG  150  reset value of the G coefficient
//  DEF_CB  29   reset value of the B coefficient
// PORTS
//  clk        in   1       system clock, all logic rising-edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       RGB pixel present
//  in_ready   out  1       block accepts pixel this cycle
//  in_R       in   PIX_W   red channel
//  in_G       in   PIX_W   green channel
//  in_B       in   PIX_W   blue channel
//  out_valid  out  1       grey result present
//  out_ready  in   1       sink accepts result this cycle
//  grey       out  PIX_W   luma result
//  sat        out  1       qualifies grey: result clipped to max
//  cfg_we     in   1       coefficient write strobe
//  cfg_sel    in   2       0=cR 1=cG 2=cB 3=ignored
//  cfg_data   in   COEF_W  coefficient write data
//  busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE, acc=0, grey=0, sat=0, out_valid=0, in_ready=1 (comb),
//    shadow and active coefficients = DEF_CR/DEF_CG/DEF_CB.
//  - States: IDLE, MUL_R, MUL_G, MUL_B, OUT.
//  - Accept = in_valid & in_ready. in_ready = (state==IDLE) | (state==OUT & out_ready).
//    On accept: latch R,G,B; copy shadow -> active coefficients; next state MUL_R.
//  - MUL_R: acc <= R*cR;        -> MUL_G.   MUL_G: acc <= acc + G*cG;  -> MUL_B.
//  - MUL_B: sum = acc + B*cB; grey <= (sum>>8 > 2^PIX_W-1) ? all-ones : sum[PIX_W+7:8];
//    sat <= overflow; out_valid <= 1; -> OUT. Multiplier shared: one product per cycle.
//  - Latency: out_valid rises on the 3rd rising edge after the accept edge (accept edge = 0).
//  - OUT: grey/sat/out_valid held stable while out_ready=0. On out_ready=1: out_valid<=0,
//    -> IDLE; if accept in the same cycle -> MUL_R directly (back-to-back).
//    Max throughput 1 pixel / 4 cycles.
//  - Arithmetic unsigned; products 2*PIX_W bits, zero-extended to ACC_W; no wrap in acc.
//  - Config: cfg_we writes shadow[cfg_sel] in any state; cfg_sel=3 writes nothing. Active
//    coefficients change only on accept, so a pixel in flight never mixes coefficient sets.
//    cfg_we coincident with accept: the accepted pixel uses the OLD shadow value; the new
//    value applies from the next pixel.
//  - in_R/G/B are don't-care when not accepted; inputs are not sampled outside accept.
//  - Reset asserted mid-operation aborts the pixel immediately; no output is produced for it.
// TESTING
//  T1 reset defaults: R=G=B=255, out_ready=1 -> grey=0xFF (sum 65280>>8=255), sat=0, lat=3.
//  T2 NTSC: R=200,G=100,B=50 -> sum=15400+15000+1450=31850 -> grey=124, sat=0.
//  T3 backpressure: hold out_ready=0 for 10 cycles -> grey/out_valid stable, in_ready=0;
//     release with in_valid=1 -> accept on the same cycle, next result 3 edges later.
//  T4 config/saturation: write cR=cG=cB=255, pixel 255,255,255 -> grey=0xFF, sat=1;
//     write cG=0 during MUL_G -> in-flight result unchanged, next pixel uses cG=0.
//  T5 streaming: 8 pixels with in_valid and out_ready held at 1 -> 8 results, 1 per
//     4 cycles, in order, matching the reference model.
//  T6 reset mid-MUL_G: rst_n low 1 cycle -> out_valid=0, in_ready=1, coefficients = 77/150/29.

Source files
------------

// File: rtl/grey_mac_sched.sv
// rtl/grey_mac_sched.sv - time-multiplexed RGB-to-luma engine, one shared multiplier over three cycles
module grey_mac_sched #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 18,
    parameter int DEF_CR = 77,
    parameter int DEF_CG = 150,
    parameter int DEF_CB = 29
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_R,
    input  logic [PIX_W-1:0]  in_G,
    input  logic [PIX_W-1:0]  in_B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  grey,
    output logic              sat,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [COEF_W-1:0] cfg_data,
    output logic              busy
);

    localparam int PROD_W = PIX_W + COEF_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_R = 3'd1,
        MUL_G = 3'd2,
        MUL_B = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic              accept;
    logic [PIX_W-1:0]  r_q, g_q, b_q;
    logic [COEF_W-1:0] sh_r, sh_g, sh_b;
    logic [COEF_W-1:0] act_r, act_g, act_b;
    logic [PIX_W-1:0]  mul_a;
    logic [COEF_W-1:0] mul_b;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc, acc_base, sum;
    logic              ovf;

    // Operand selection for the single multiplier follows the state sequence.
    always_comb begin
        in_ready  = (state == IDLE) || ((state == OUT) && out_ready);
        accept    = in_valid && in_ready;
        state_nxt = state;
        mul_a     = r_q;
        mul_b     = act_r;
        case (state)
            IDLE:  if (accept) state_nxt = MUL_R;
            MUL_R: state_nxt = MUL_G;
            MUL_G: begin
                mul_a     = g_q;
                mul_b     = act_g;
                state_nxt = MUL_B;
            end
            MUL_B: begin
                mul_a     = b_q;
                mul_b     = act_b;
                state_nxt = OUT;
            end
            OUT: begin
                if (out_ready) state_nxt = accept ? MUL_R : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign prod     = PROD_W'(mul_a) * PROD_W'(mul_b);
    assign acc_base = (state == MUL_R) ? '0 : acc;
    assign sum      = acc_base + ACC_W'(prod);
    assign ovf      = |sum[ACC_W-1:PIX_W+8];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Shadow coefficients take writes at any time; the active set is only
    // refreshed on accept so a pixel in flight never sees a mixed set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r <= COEF_W'(DEF_CR);
            sh_g <= COEF_W'(DEF_CG);
            sh_b <= COEF_W'(DEF_CB);
        end else if (cfg_we) begin
            case (cfg_sel)
                2'd0:    sh_r <= cfg_data;
                2'd1:    sh_g <= cfg_data;
                2'd2:    sh_b <= cfg_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            act_r <= COEF_W'(DEF_CR);
            act_g <= COEF_W'(DEF_CG);
            act_b <= COEF_W'(DEF_CB);
        end else if (accept) begin
            r_q   <= in_R;
            g_q   <= in_G;
            b_q   <= in_B;
            act_r <= sh_r;
            act_g <= sh_g;
            act_b <= sh_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            grey      <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                MUL_R, MUL_G: acc <= sum;
                MUL_B: begin
                    grey      <= ovf ? '1 : sum[PIX_W+7:8];
                    sat       <= ovf;
                    out_valid <= 1'b1;
                end
                OUT: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grey_mac_sched.sv
// tb/tb_grey_mac_sched.sv - scoreboard bench for grey_mac_sched
module tb_grey_mac_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_R = '0, in_G = '0, in_B = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] grey;
    logic       sat;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_sel = '0;
    logic [7:0] cfg_data = '0;
    logic       busy;

    int total = 0;
    int bad = 0;
    logic [8:0] exp_q[$];
    int m_cr = 77, m_cg = 150, m_cb = 29;

    grey_mac_sched dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_R(in_R), .in_G(in_G), .in_B(in_B),
        .out_valid(out_valid), .out_ready(out_ready),
        .grey(grey), .sat(sat),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [8:0] model(input int r, g, b, cr, cg, cb);
        int s;
        s = (r * cr + g * cg + b * cb) >> 8;
        if (s > 255) return {1'b1, 8'hFF};
        return {1'b0, s[7:0]};
    endfunction

    // Monitor: a transfer completes at the posedge after a negedge with valid & ready.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got grey=%0d sat=%0d expected none", grey, sat);
            end else begin
                e = exp_q.pop_front();
                check("grey", int'(grey), int'(e[7:0]));
                check("sat", int'(sat), int'(e[8]));
            end
        end
    end

    task automatic send(input logic [7:0] r, g, b, input logic [8:0] e, input bit push,
                        output int waited);
        int n = 0;
        in_R = r; in_G = g; in_B = b; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("accept_timeout", 0, 1);
        @(posedge clk);
        if (push) exp_q.push_back(e);
        #1 in_valid = 1'b0;
        waited = n;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [7:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        if (sel == 2'd0) m_cr = data;
        if (sel == 2'd1) m_cg = data;
        if (sel == 2'd2) m_cb = data;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            if (!busy && !out_valid && exp_q.size() == 0) break;
            n++;
        end
        if (n >= 100) check("idle_timeout", 0, 1);
    endtask

    task automatic latency_check(input string name);
        int k = 1;
        while (k < 10) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
            k++;
        end
        check(name, k, 3);
    endtask

    initial begin
        int w;
        longint t_prev;
        logic [7:0] pr[8] = '{8'd0, 8'd255, 8'd12, 8'd200, 8'd90, 8'd1, 8'd128, 8'd64};
        logic [7:0] pg[8] = '{8'd0, 8'd0, 8'd34, 8'd100, 8'd180, 8'd2, 8'd128, 8'd250};
        logic [7:0] pb[8] = '{8'd0, 8'd0, 8'd56, 8'd50, 8'd45, 8'd3, 8'd128, 8'd7};

        // reset state
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_grey", int'(grey), 0);
        check("rst_sat", int'(sat), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // T1: default coefficients sum to 256, white stays 255; latency 3
        send(8'd255, 8'd255, 8'd255, {1'b0, 8'd255}, 1'b1, w);
        latency_check("t1_latency");
        wait_idle();

        // T2: NTSC vector -> 31850 >> 8 = 124
        send(8'd200, 8'd100, 8'd50, {1'b0, 8'd124}, 1'b1, w);
        wait_idle();

        // T3: backpressure, 770+3000+870=4640 -> 18
        out_ready = 1'b0;
        send(8'd10, 8'd20, 8'd30, {1'b0, 8'd18}, 1'b1, w);
        latency_check("t3_latency");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("t3_hold_valid", int'(out_valid), 1);
            check("t3_hold_grey", int'(grey), 18);
            check("t3_hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        send(8'd100, 8'd0, 8'd0, {1'b0, 8'd30}, 1'b1, w);
        check("t3_same_cycle_accept", w, 0);
        latency_check("t3_b2b_latency");
        wait_idle();

        // T4: all coefficients 255 -> saturation
        cfg_write(2'd0, 8'd255);
        cfg_write(2'd1, 8'd255);
        cfg_write(2'd2, 8'd255);
        send(8'd255, 8'd255, 8'd255, {1'b1, 8'hFF}, 1'b1, w);
        wait_idle();
        // cG written during MUL_G: in-flight 60*255=15300 -> 59
        send(8'd10, 8'd20, 8'd30, {1'b0, 8'd59}, 1'b1, w);
        @(posedge clk);
        #1 check("t4_in_mul_g_busy", int'(busy), 1);
        cfg_write(2'd1, 8'd0);
        wait_idle();
        // cR write coincident with accept: pixel still uses cR=255 -> 10200 -> 39
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd0;
        send(8'd10, 8'd20, 8'd30, {1'b0, 8'd39}, 1'b1, w);
        cfg_we = 1'b0;
        m_cr = 0;
        wait_idle();
        // next pixel sees cR=0: 30*255=7650 -> 29
        send(8'd10, 8'd20, 8'd30, {1'b0, 8'd29}, 1'b1, w);
        wait_idle();

        // T5: streaming with NTSC coefficients
        cfg_write(2'd0, 8'd77);
        cfg_write(2'd1, 8'd150);
        cfg_write(2'd2, 8'd29);
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            send(pr[i], pg[i], pb[i], model(pr[i], pg[i], pb[i], m_cr, m_cg, m_cb), 1'b1, w);
            if (i > 0) check("t5_period", int'($time - t_prev), 40);
            t_prev = $time;
        end
        wait_idle();

        // T6: reset in MUL_G aborts pixel and restores default coefficients
        cfg_write(2'd0, 8'd0);
        send(8'd200, 8'd100, 8'd50, 9'd0, 1'b0, w);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_out_valid", int'(out_valid), 0);
        check("t6_in_ready", int'(in_ready), 1);
        check("t6_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_cr = 77;
        send(8'd200, 8'd100, 8'd50, {1'b0, 8'd124}, 1'b1, w);
        wait_idle();
        repeat (6) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
